// File: rtl/barret_811_pkg.sv
// Shared constants and types for the mod-811 Barrett reduction scheduler.
package barret_811_pkg;

  localparam int unsigned Q      = 811;
  localparam int unsigned MU     = 1292;  // floor(2^20 / 811)
  localparam int unsigned K      = 10;
  localparam int unsigned DIN_W  = 19;
  localparam int unsigned DOUT_W = 10;

  typedef logic [DIN_W-1:0]  din_t;
  typedef logic [DOUT_W-1:0] res_t;

  // One conditional subtraction of Q on a 20-bit partial residue.
  function automatic logic [19:0] cond_sub(input logic [19:0] r);
    return (r >= 20'(Q)) ? (r - 20'(Q)) : r;
  endfunction

endpackage

// File: rtl/barret_811_pipe.sv
// Two-stage mod-811 Barrett reduction with a pass-through requester tag.
// All registers advance only when en is high; bubbles travel like data.
module barret_811_pipe
  import barret_811_pkg::*;
#(
  parameter int unsigned ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  din_t            in_x,
  input  logic [ID_W-1:0] in_id,
  output logic            v1,
  output logic            out_valid,
  output res_t            out_data,
  output logic [ID_W-1:0] out_id
);

  din_t            x1_q;
  logic [ID_W-1:0] id1_q;
  logic [9:0]      t1_q;
  logic [19:0]     prod;
  logic [9:0]      t_d;
  logic [19:0]     r0, r1, r2;

  // Quotient estimate: 9-bit high part times 11-bit MU, full 20-bit product.
  always_comb begin
    prod = 20'(in_x[DIN_W-1:K]) * 20'(MU);
    t_d  = 10'(prod >> K);
  end

  // Stage 1: capture operand, tag and quotient estimate on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      x1_q  <= '0;
      id1_q <= '0;
      t1_q  <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1_q  <= in_x;
        id1_q <= in_id;
        t1_q  <= t_d;
      end
    end
  end

  // Remainder with at most two corrective subtractions; estimate is short by <= 2.
  always_comb begin
    r0 = 20'(x1_q) - (20'(t1_q) * 20'(Q));
    r1 = cond_sub(r0);
    r2 = cond_sub(r1);
  end

  // Stage 2: output register, held while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (en) begin
      out_valid <= v1;
      out_data  <= DOUT_W'(r2);
      out_id    <= id1_q;
    end
  end

endmodule

// File: rtl/barret_811_sched.sv
// Round-robin scheduler sharing one mod-811 reduction pipe among N_REQ requesters.
// Optional result-handshake counter port perf_cnt under macro BARRET_811_PERF_EN.
module barret_811_sched
  import barret_811_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output res_t                   out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   out_ready,
  output logic                   busy
`ifdef BARRET_811_PERF_EN
  ,
  output logic [31:0]            perf_cnt
`endif
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] win;
  logic            found;
  logic            adv;
  logic            transfer;
  logic            v1;
  din_t            in_x;

  // Whole pipe moves together; rst_n gating keeps req_ready low during reset.
  assign adv      = rst_n && (!out_valid || out_ready);
  assign transfer = found && adv;

  // Rotating priority search starting at ptr.
  always_comb begin
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Grant, operand mux and next pointer.
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win] = 1'b1;
    in_x  = req_data[32'(win)*DIN_W +: DIN_W];
    ptr_d = ptr_q;
    if (transfer) begin
      if (32'(win) == N_REQ - 1) ptr_d = '0;
      else                       ptr_d = win + ID_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  barret_811_pipe #(
    .ID_W (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv),
    .in_valid  (transfer),
    .in_x      (in_x),
    .in_id     (win),
    .v1        (v1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  assign busy = v1 || out_valid;

`ifdef BARRET_811_PERF_EN
  logic [31:0] perf_q;

  // Count accepted results, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      perf_q <= '0;
    else if (out_valid && out_ready) perf_q <= perf_q + 32'd1;
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_barret_811_sched.sv
// Directed self-checking bench for barret_811_sched (N_REQ = 4).
module tb_barret_811_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [75:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [9:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic        busy;
`ifdef BARRET_811_PERF_EN
  logic [31:0] perf_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [18:0] xs_q[$];
  logic [9:0]  es_q[$];

  barret_811_sched #(
    .N_REQ (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef BARRET_811_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [18:0] x);
    req_data[i*19 +: 19] = x;
    req_valid[i]         = 1'b1;
  endtask

  // Streams xs_q back-to-back through requester 0 and checks results against es_q.
  task automatic stream0(input string tag);
    int n;
    n = xs_q.size();
    for (int k = 0; k < n + 1; k++) begin
      if (k < n) set_req(0, xs_q[k]);
      else       req_valid = '0;
      #1;
      if (k < n) check({tag, "_ready"}, 32'(req_ready), 32'b0001);
      tick();
      if (k >= 1) begin
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(es_q[k-1]));
        check({tag, "_lt811"}, 32'(out_data < 10'd811), 32'd1);
      end
    end
    tick();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [18:0] x;
    logic [18:0] ops[4];
    logic [9:0]  res[4];
    ops[0] = 19'd2438;   res[0] = 10'd5;
    ops[1] = 19'd8210;   res[1] = 10'd100;
    ops[2] = 19'd81800;  res[2] = 10'd700;
    ops[3] = 19'd486601; res[3] = 10'd1;

    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    // Reset state, with a pending request that must not be granted
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef BARRET_811_PERF_EN
    check("rst_perf", perf_cnt, 32'd0);
`endif
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Single operand latency: 123456 mod 811 = 184
    set_req(0, 19'd123456);
    #1;
    check("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check("single_lat1_valid", 32'(out_valid), 32'd0);
    check("single_lat1_busy", 32'(busy), 32'd1);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'd184);
    check("single_id", 32'(out_id), 32'd0);
    tick();
    check("single_after_valid", 32'(out_valid), 32'd0);
    check("single_after_busy", 32'(busy), 32'd0);

    // Boundary operands
    xs_q = '{19'd0, 19'd810, 19'd811, 19'd1621, 19'd524287};
    es_q = '{10'd0, 10'd810, 10'd0, 10'd810, 10'd381};
    stream0("bound");

    // Strided sweep across the full operand range, reference is plain modulo
    xs_q.delete();
    es_q.delete();
    for (int i = 0; i < 20000; i++) begin
      x = 19'(i * 26 + (i % 26));
      xs_q.push_back(x);
      es_q.push_back(10'(x % 19'd811));
    end
    stream0("sweep");

    // Backpressure: A on req1, B on req2 in flight, then stall 5 cycles
    set_req(1, 19'd1000);
    #1;
    check("bp_grant_a", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    set_req(2, 19'd5000);
    #1;
    check("bp_grant_b", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    out_ready = 1'b0;
    set_req(3, 19'd20000);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'd189);
      check("bp_hold_id", 32'(out_id), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      check("bp_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    check("bp_end_data", 32'(out_data), 32'd189);
    out_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_data", 32'(out_data), 32'd134);
    check("bp_b_id", 32'(out_id), 32'd2);
    tick();
    check("bp_c_valid", 32'(out_valid), 32'd1);
    check("bp_c_data", 32'(out_data), 32'd536);
    check("bp_c_id", 32'(out_id), 32'd3);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream with two operands in flight and ptr away from 0
    set_req(1, 19'd111);
    #1;
    check("mr_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    set_req(2, 19'd222);
    tick();
    req_valid = '0;
    check("mr_inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    check("mr_out_id", 32'(out_id), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
`ifdef BARRET_811_PERF_EN
    check("mr_perf", perf_cnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    // Full contention: grants must rotate 0,1,2,3 starting from the reset pointer
    for (int i = 0; i < 4; i++) set_req(i, ops[i]);
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
      if (c >= 1) begin
        check("rr_valid", 32'(out_valid), 32'd1);
        check("rr_id", 32'(out_id), 32'((c - 1) % 4));
        check("rr_data", 32'(out_data), 32'(res[(c - 1) % 4]));
      end
    end
    req_valid = '0;
    tick();
    check("rr_last_id", 32'(out_id), 32'd3);
    check("rr_last_data", 32'(out_data), 32'(res[3]));
    tick();
    check("rr_drained", 32'(out_valid), 32'd0);
`ifdef BARRET_811_PERF_EN
    check("rr_perf", perf_cnt, 32'd8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
